// File: rtl/ddr3_cmd_bus_driver_pkg.sv
// Shared types and DDR3 pin encodings for the command bus driver.
package ddr3_cmd_bus_driver_pkg;

  localparam int BA_BITS   = 3;
  localparam int ADDR_BITS = 14;
  localparam int ROW_BITS  = 14;
  localparam int COL_BITS  = 10;

  // Scheduler command codes; codes above SCH_POWER_U are undefined.
  typedef enum logic [3:0] {
    SCH_NOP       = 4'd0,
    SCH_ACTIVE    = 4'd1,
    SCH_READ      = 4'd2,
    SCH_RDA       = 4'd3,
    SCH_WRITE     = 4'd4,
    SCH_WRA       = 4'd5,
    SCH_PRECHARGE = 4'd6,
    SCH_REFRESH   = 4'd7,
    SCH_POWER_D   = 4'd8,
    SCH_POWER_U   = 4'd9
  } sch_cmd_t;

  typedef enum logic {
    BL_4 = 1'b0,
    BL_8 = 1'b1
  } bl_t;

  typedef struct packed {
    sch_cmd_t                     cmd;
    logic [BA_BITS-1:0]           bank;
    logic [ROW_BITS+COL_BITS-1:0] addr;
  } issue_fifo_cmd_in_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  localparam int A10_AP_BIT = 10;
  localparam int A12_BL_BIT = 12;

  typedef struct packed {
    logic                 cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [BA_BITS-1:0]   ba;
    logic [ADDR_BITS-1:0] a;
  } ddr_cmd_pins_t;

endpackage

// File: rtl/ddr3_cmd_bus_driver_burst_window_gen.sv
// One direction's data window: a one-hot pending shift register carries each
// issued column command down to the burst start, then a small counter holds
// the window open for 2 (BL_4) or 4 (BL_8) clocks.
module burst_window_gen
  import ddr3_cmd_bus_driver_pkg::*;
#(
  parameter int LAT   = 5,
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bl8,
  output logic win
);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_len;
  logic [1:0]       remain;
  logic             win_q;

  // Shift pending slots toward slot 0; slot 0 set means the burst begins now.
  // A start is inserted at LAT-1 so the window opens LAT clocks after the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      pend_len <= '0;
      remain   <= '0;
      win_q    <= 1'b0;
    end else begin
      pend     <= {1'b0, pend[DEPTH-1:1]};
      pend_len <= {1'b0, pend_len[DEPTH-1:1]};
      if (start) begin
        pend[LAT-1]     <= 1'b1;
        pend_len[LAT-1] <= bl8;
      end
      // A new burst takes priority so back-to-back bursts join without a gap.
      if (pend[0]) begin
        win_q  <= 1'b1;
        remain <= pend_len[0] ? 2'd3 : 2'd1;
      end else if (remain != 2'd0) begin
        win_q  <= 1'b1;
        remain <= remain - 2'd1;
      end else begin
        win_q  <= 1'b0;
      end
    end
  end

  assign win = win_q;

endmodule

// File: rtl/ddr3_cmd_bus_driver.sv
// Issue-FIFO consumer: encodes one scheduled command per handshake onto the
// registered DDR3 command/address pins, drives CKE and produces the write-data
// and read-capture windows.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on registered state (reset
// flag and tCCD counter) and the source holds cmd_in/cmd_bl while waiting.
module ddr3_cmd_bus_driver
  import ddr3_cmd_bus_driver_pkg::*;
#(
  parameter int CL   = 5,
  parameter int CWL  = 5,
  parameter int TCCD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  issue_fifo_cmd_in_t   cmd_in,
  input  bl_t                  cmd_bl,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] a,
  output logic                 wdata_en,
  output logic                 rdata_capture,
  output logic                 cmd_err
);

  localparam int TW    = (TCCD > 1) ? $clog2(TCCD) : 1;
  localparam int DEPTH = ((CL > CWL) ? CL : CWL) + 4;
  localparam logic [TW-1:0] TCCD_LOAD = TW'(TCCD - 1);

  ddr_cmd_pins_t        pins_q, pins_d;
  logic                 cke_q, cke_d;
  logic                 err_q, err_d;
  logic                 rst_q;
  logic [TW-1:0]        tccd_cnt;
  logic                 accept;
  logic                 rd_start, wr_start;
  logic [3:0]           code_d;
  logic [BA_BITS-1:0]   ba_d;
  logic [ADDR_BITS-1:0] a_d;
  logic [ROW_BITS-1:0]  row;
  logic [COL_BITS-1:0]  col;
  logic [ADDR_BITS-1:0] col_a;

  assign cmd_ready = !rst_q && (tccd_cnt == '0);
  assign accept    = cmd_valid && cmd_ready;
  assign row       = cmd_in.addr[ROW_BITS+COL_BITS-1:COL_BITS];
  assign col       = cmd_in.addr[COL_BITS-1:0];

  // Decode the accepted command into next pin values, CKE and window starts.
  always_comb begin
    code_d   = CMD_NOP;
    ba_d     = pins_q.ba;
    a_d      = pins_q.a;
    cke_d    = cke_q;
    err_d    = 1'b0;
    rd_start = 1'b0;
    wr_start = 1'b0;
    col_a    = '0;
    col_a[COL_BITS-1:0] = col;
    col_a[A10_AP_BIT]   = (cmd_in.cmd == SCH_RDA) || (cmd_in.cmd == SCH_WRA);
    col_a[A12_BL_BIT]   = (cmd_bl == BL_8);
    if (accept) begin
      if (!cke_q) begin
        // Powered down: only POWER_U does anything; other known commands error.
        case (cmd_in.cmd)
          SCH_POWER_U: cke_d = 1'b1;
          SCH_ACTIVE, SCH_READ, SCH_RDA, SCH_WRITE, SCH_WRA,
          SCH_PRECHARGE, SCH_REFRESH, SCH_POWER_D: err_d = 1'b1;
          default: ;
        endcase
      end else begin
        case (cmd_in.cmd)
          SCH_ACTIVE: begin
            code_d = CMD_ACT;
            ba_d   = cmd_in.bank;
            a_d    = row;
          end
          SCH_READ, SCH_RDA: begin
            code_d   = CMD_RD;
            ba_d     = cmd_in.bank;
            a_d      = col_a;
            rd_start = 1'b1;
          end
          SCH_WRITE, SCH_WRA: begin
            code_d   = CMD_WR;
            ba_d     = cmd_in.bank;
            a_d      = col_a;
            wr_start = 1'b1;
          end
          SCH_PRECHARGE: begin
            code_d = CMD_PRE;
            ba_d   = cmd_in.bank;
            a_d    = '0;
          end
          SCH_REFRESH: begin
            code_d = CMD_REF;
            a_d    = '0;
          end
          SCH_POWER_D: cke_d = 1'b0;
          SCH_POWER_U: cke_d = 1'b1;
          default: ;
        endcase
      end
    end
    pins_d = '{cs_n: code_d[3], ras_n: code_d[2], cas_n: code_d[1],
               we_n: code_d[0], ba: ba_d, a: a_d};
  end

  // Pin, CKE, error and tCCD registers; reset leaves the bus deselected.
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_q   <= '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                    ba: '0, a: '0};
      cke_q    <= 1'b0;
      err_q    <= 1'b0;
      rst_q    <= 1'b1;
      tccd_cnt <= '0;
    end else begin
      pins_q <= pins_d;
      cke_q  <= cke_d;
      err_q  <= err_d;
      rst_q  <= 1'b0;
      if (rd_start || wr_start) begin
        tccd_cnt <= TCCD_LOAD;
      end else if (tccd_cnt != '0) begin
        tccd_cnt <= tccd_cnt - 1'b1;
      end
    end
  end

  burst_window_gen #(.LAT(CWL), .DEPTH(DEPTH)) u_wr_win (
    .clk   (clk),
    .rst   (rst),
    .start (wr_start),
    .bl8   (cmd_bl == BL_8),
    .win   (wdata_en)
  );

  burst_window_gen #(.LAT(CL), .DEPTH(DEPTH)) u_rd_win (
    .clk   (clk),
    .rst   (rst),
    .start (rd_start),
    .bl8   (cmd_bl == BL_8),
    .win   (rdata_capture)
  );

  assign cke     = cke_q;
  assign cs_n    = pins_q.cs_n;
  assign ras_n   = pins_q.ras_n;
  assign cas_n   = pins_q.cas_n;
  assign we_n    = pins_q.we_n;
  assign ba      = pins_q.ba;
  assign a       = pins_q.a;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_ddr3_cmd_bus_driver.sv
// Directed bench for ddr3_cmd_bus_driver: inputs change 1 time unit after
// the rising edge and outputs are checked at that same point.
module tb_ddr3_cmd_bus_driver;
  import ddr3_cmd_bus_driver_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  issue_fifo_cmd_in_t   cmd_in;
  bl_t                  cmd_bl;
  logic                 cke, cs_n, ras_n, cas_n, we_n;
  logic [BA_BITS-1:0]   ba;
  logic [ADDR_BITS-1:0] a;
  logic                 wdata_en, rdata_capture, cmd_err;

  int passed = 0;
  int total  = 0;

  ddr3_cmd_bus_driver #(.CL(5), .CWL(5), .TCCD(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_in        (cmd_in),
    .cmd_bl        (cmd_bl),
    .cke           (cke),
    .cs_n          (cs_n),
    .ras_n         (ras_n),
    .cas_n         (cas_n),
    .we_n          (we_n),
    .ba            (ba),
    .a             (a),
    .wdata_en      (wdata_en),
    .rdata_capture (rdata_capture),
    .cmd_err       (cmd_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pins();
    return 32'({cs_n, ras_n, cas_n, we_n});
  endfunction

  // Present a command, wait (bounded) for cmd_ready, complete the handshake.
  // Returns in the pin cycle of the accepted command.
  task automatic issue(input sch_cmd_t c, input logic [BA_BITS-1:0] bk,
                       input logic [ROW_BITS+COL_BITS-1:0] ad, input bl_t b);
    int n = 0;
    cmd_in.cmd  = c;
    cmd_in.bank = bk;
    cmd_in.addr = ad;
    cmd_bl      = b;
    cmd_valid   = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++;
      $error("FAIL issue_timeout observed=0x0 expected=0x1");
      cmd_valid = 1'b0;
    end else begin
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_in    = '0;
    cmd_bl    = BL_4;
    repeat (3) tick();

    // Reset state
    chk("rst_pins",  pins(), 32'hF);
    chk("rst_cke",   32'(cke), 32'h0);
    chk("rst_ba",    32'(ba), 32'h0);
    chk("rst_a",     32'(a), 32'h0);
    chk("rst_wden",  32'(wdata_en), 32'h0);
    chk("rst_rcap",  32'(rdata_capture), 32'h0);
    chk("rst_err",   32'(cmd_err), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);
    chk("post_rst_pins",  pins(), 32'h7);

    // POWER_U then ACTIVE bank 3 row 0x1A5
    issue(SCH_POWER_U, 3'd0, 24'h0, BL_4);
    chk("pu_cke",  32'(cke), 32'h1);
    chk("pu_pins", pins(), 32'h7);
    chk("pu_err",  32'(cmd_err), 32'h0);
    issue(SCH_ACTIVE, 3'd3, {14'h1A5, 10'h000}, BL_4);
    chk("act_pins",  pins(), 32'h3);
    chk("act_ba",    32'(ba), 32'h3);
    chk("act_a",     32'(a), 32'h1A5);
    chk("act_ready", 32'(cmd_ready), 32'h1);
    tick();
    chk("act_nop_pins", pins(), 32'h7);
    chk("act_nop_a",    32'(a), 32'h1A5);
    chk("act_nop_ba",   32'(ba), 32'h3);
    chk("act_nop_ready", 32'(cmd_ready), 32'h1);

    // PRECHARGE, REFRESH, undefined code
    issue(SCH_PRECHARGE, 3'd5, 24'hFFFFFF, BL_8);
    chk("pre_pins", pins(), 32'h2);
    chk("pre_ba",   32'(ba), 32'h5);
    chk("pre_a10",  32'(a[10]), 32'h0);
    issue(SCH_REFRESH, 3'd2, 24'h12345, BL_8);
    chk("ref_pins", pins(), 32'h1);
    chk("ref_a",    32'(a), 32'h0);
    issue(sch_cmd_t'(4'hF), 3'd1, 24'h3FF, BL_8);
    chk("undef_pins", pins(), 32'h7);
    chk("undef_err",  32'(cmd_err), 32'h0);

    // WRITE bank 1 col 0x08 BL_8: window T+6..T+9
    issue(SCH_WRITE, 3'd1, {14'h0, 10'h008}, BL_8);
    chk("wr_pins",  pins(), 32'h4);
    chk("wr_ba",    32'(ba), 32'h1);
    chk("wr_a",     32'(a), 32'h1008);
    chk("wr_ready", 32'(cmd_ready), 32'h0);
    for (int k = 1; k <= 11; k++) begin
      chk("wr_win", 32'(wdata_en), 32'(k >= 6 && k <= 9));
      chk("wr_no_rcap", 32'(rdata_capture), 32'h0);
      tick();
    end

    // RDA col 0x3F BL_4, READ BL_8 held from T+1, accepted at T+4
    issue(SCH_RDA, 3'd2, {14'h0, 10'h03F}, BL_4);
    chk("rda_pins", pins(), 32'h5);
    chk("rda_a",    32'(a), 32'h043F);
    cmd_in.cmd  = SCH_READ;
    cmd_in.bank = 3'd2;
    cmd_in.addr = {14'h0, 10'h010};
    cmd_bl      = BL_8;
    cmd_valid   = 1'b1;
    chk("tccd_ready_t1", 32'(cmd_ready), 32'h0);
    tick();
    chk("tccd_ready_t2", 32'(cmd_ready), 32'h0);
    chk("tccd_hold_pins", pins(), 32'h7);
    tick();
    chk("tccd_ready_t3", 32'(cmd_ready), 32'h0);
    tick();
    chk("tccd_ready_t4", 32'(cmd_ready), 32'h1);
    tick();
    cmd_valid = 1'b0;
    chk("rd2_pins", pins(), 32'h5);
    chk("rd2_a",    32'(a), 32'h1010);
    for (int k = 5; k <= 14; k++) begin
      chk("rd_bl4_bl8_win", 32'(rdata_capture),
          32'(k == 6 || k == 7 || (k >= 10 && k <= 13)));
      tick();
    end

    // Two READ BL_8 at T and T+4: contiguous window T+6..T+13
    issue(SCH_READ, 3'd0, {14'h0, 10'h020}, BL_8);
    issue(SCH_READ, 3'd0, {14'h0, 10'h028}, BL_8);
    for (int k = 5; k <= 15; k++) begin
      chk("rd_b2b_win", 32'(rdata_capture), 32'(k >= 6 && k <= 13));
      chk("rd_b2b_no_wden", 32'(wdata_en), 32'h0);
      tick();
    end

    // POWER_D, WRITE while cke=0, POWER_U
    issue(SCH_POWER_D, 3'd0, 24'h0, BL_4);
    chk("pd_cke",  32'(cke), 32'h0);
    chk("pd_pins", pins(), 32'h7);
    chk("pd_err",  32'(cmd_err), 32'h0);
    issue(SCH_WRITE, 3'd1, {14'h0, 10'h008}, BL_8);
    chk("pdwr_pins", pins(), 32'h7);
    chk("pdwr_err",  32'(cmd_err), 32'h1);
    chk("pdwr_cke",  32'(cke), 32'h0);
    tick();
    chk("pdwr_err_pulse", 32'(cmd_err), 32'h0);
    for (int k = 2; k <= 10; k++) begin
      chk("pdwr_no_wden", 32'(wdata_en), 32'h0);
      tick();
    end
    issue(SCH_POWER_U, 3'd0, 24'h0, BL_4);
    chk("pu2_cke", 32'(cke), 32'h1);
    chk("pu2_err", 32'(cmd_err), 32'h0);

    // WRITE BL_8 at T, reset during T+3
    issue(SCH_WRITE, 3'd4, {14'h0, 10'h100}, BL_8);
    chk("rstwr_pins", pins(), 32'h4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_pins",  pins(), 32'hF);
    chk("mid_rst_ready", 32'(cmd_ready), 32'h0);
    chk("mid_rst_cke",   32'(cke), 32'h0);
    tick();
    chk("after_rst_ready", 32'(cmd_ready), 32'h1);
    chk("after_rst_pins",  pins(), 32'h7);
    for (int k = 5; k <= 12; k++) begin
      chk("rst_abort_wden", 32'(wdata_en), 32'h0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
